// File: rtl/psrv_pkg.sv
// Shared PSRV32 definitions: hazard FSM states, forwarding selects, opcodes
// and the per-operand forwarding priority function.
package psrv_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BUBBLE  = 2'd1,
        ST_MEMWAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } hz_en_t;

    // Youngest producer wins; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mem_rd,
                                           input logic       mem_we,
                                           input logic [4:0] wb_rd,
                                           input logic       wb_we);
        if (mem_we && mem_rd != 5'd0 && mem_rd == src) return FWD_MEM;
        if (wb_we && wb_rd != 5'd0 && wb_rd == src)    return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// ALU operand forwarding selects for both EX source operands.
module forward_unit
    import psrv_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);
    logic [1:0][4:0] src;
    logic [1:0][1:0] sel;

    assign src = {ex_rs2, ex_rs1};

    for (genvar i = 0; i < 2; i++) begin : g_op
        assign sel[i] = fwd_sel(src[i], mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

    assign fwd_a = sel[0];
    assign fwd_b = sel[1];
endmodule

// File: rtl/hazard_ctrl.sv
// PSRV32 hazard controller: load-use bubbles, data-memory freeze, redirect
// flushes, operand forwarding and a free-running stall-cycle counter.
module hazard_ctrl
    import psrv_pkg::*;
#(
    parameter int unsigned LU_BUBBLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rs1_i,
    input  logic [4:0]  ex_rs2_i,
    input  logic        ex_redirect_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_reg_write_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        wb_reg_write_i,
    input  logic        mem_req_i,
    input  logic        dmem_ready_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        ex_mem_en_o,
    output logic        mem_wb_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o,
    output logic [31:0] stall_cycles_o
);
    hz_state_e   state_q, state_d;
    logic [2:0]  bub_q, bub_d;
    logic [31:0] stall_cnt_q;
    hz_en_t      en;
    logic        flush_if, flush_id;
    logic        lu, mw;
    logic [1:0]  fwd_a, fwd_b;

    assign lu = ex_mem_read_i && ex_rd_i != 5'd0 &&
                (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
    assign mw = mem_req_i && !dmem_ready_i;

    // MEMWAIT with memory ready behaves exactly like RUN, so a redirect or
    // load-use held in EX during the freeze is acted on as the freeze ends.
    always_comb begin
        en       = '1;
        flush_if = 1'b0;
        flush_id = 1'b0;
        state_d  = ST_RUN;
        bub_d    = 3'd0;
        if (mw) begin
            en      = '0;
            state_d = ST_MEMWAIT;
        end else if (ex_redirect_i) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (state_q == ST_BUBBLE || lu) begin
            en.pc    = 1'b0;
            en.if_id = 1'b0;
            flush_id = 1'b1;
            if (state_q == ST_BUBBLE) begin
                if (bub_q > 3'd1) begin
                    state_d = ST_BUBBLE;
                    bub_d   = bub_q - 3'd1;
                end
            end else if (LU_BUBBLES > 1) begin
                state_d = ST_BUBBLE;
                bub_d   = 3'(LU_BUBBLES - 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            bub_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       stall_cnt_q <= 32'd0;
        else if (!pc_en_o) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    forward_unit u_fwd (
        .ex_rs1        (ex_rs1_i),
        .ex_rs2        (ex_rs2_i),
        .mem_rd        (mem_rd_i),
        .mem_reg_write (mem_reg_write_i),
        .wb_rd         (wb_rd_i),
        .wb_reg_write  (wb_reg_write_i),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Reset forces the safe pipeline state asynchronously, independent of the FSM.
    assign pc_en_o        = rst_ni & en.pc;
    assign if_id_en_o     = rst_ni & en.if_id;
    assign id_ex_en_o     = rst_ni & en.id_ex;
    assign ex_mem_en_o    = rst_ni & en.ex_mem;
    assign mem_wb_en_o    = rst_ni & en.mem_wb;
    assign if_id_flush_o  = !rst_ni | flush_if;
    assign id_ex_flush_o  = !rst_ni | flush_id;
    assign fwd_a_o        = rst_ni ? fwd_a : FWD_RF;
    assign fwd_b_o        = rst_ni ? fwd_b : FWD_RF;
    assign stall_cycles_o = stall_cnt_q;
endmodule
